// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/func constants, ALU op encodings and FSM states shared by the core and its ALU.
package cpu_pkg;
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_NOR  = 3'b011,
        ALU_ADD  = 3'b100,
        ALU_SUB  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_SLLV = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for the multi-cycle core.
//   a_i, b_i : operands (DATA_W)     op_i : ALU operation
//   f_o      : result                zf_o : result is zero
//   of_o     : signed overflow, only for add/sub, else 0
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] f_o,
    output logic              zf_o,
    output logic              of_o
);
    logic [DATA_W-1:0] sum, diff;

    always_comb begin
        sum  = a_i + b_i;
        diff = a_i - b_i;
        f_o  = '0;
        of_o = 1'b0;
        case (op_i)
            ALU_AND:  f_o = a_i & b_i;
            ALU_OR:   f_o = a_i | b_i;
            ALU_XOR:  f_o = a_i ^ b_i;
            ALU_NOR:  f_o = ~(a_i | b_i);
            ALU_ADD: begin
                f_o  = sum;
                of_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
            end
            ALU_SUB: begin
                f_o  = diff;
                of_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);
            end
            ALU_SLTU: f_o = DATA_W'(a_i < b_i);
            ALU_SLLV: f_o = b_i << a_i[$clog2(DATA_W)-1:0];
            default:  f_o = '0;
        endcase
        zf_o = (f_o == '0);
    end
endmodule

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: multi-cycle MIPS-subset core (IF/ID/EX/MEM/WB/HALT) with inline 32-entry register file.
//   clk, rst (async, active-low)
//   imem_addr/imem_rdata : synchronous instruction ROM (one-cycle latency)
//   dmem_we/addr/wdata/rdata : synchronous data RAM (one-cycle read latency)
//   pc, zf, of, halt : architectural status
//   dbg_we/waddr/wdata : register writeback observation port
module multi_cycle_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 6
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               zf,
    output logic               of,
    output logic               halt,
    output logic               dbg_we,
    output logic [4:0]         dbg_waddr,
    output logic [DATA_W-1:0]  dbg_wdata
);
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
    logic              zf_q, zf_d, of_q, of_d;
    logic [DATA_W-1:0] regs_q [32];

    logic [5:0]        opcode;
    logic [DATA_W-1:0] simm, zimm, alu_b, f, wdata;
    logic [4:0]        dest;
    alu_op_e           alu_op;
    logic              is_alu, alu_zf, alu_of;

    assign opcode = ir_q[31:26];
    assign simm   = DATA_W'($signed(ir_q[15:0]));
    assign zimm   = DATA_W'(ir_q[15:0]);
    assign dest   = (opcode == OP_R) ? ir_q[15:11] : ir_q[20:16];
    assign wdata  = (opcode == OP_LW) ? dmem_rdata : alu_out_q;

    // Default decode is add with sign-extended imm, which is also the lw/sw address path.
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = simm;
        is_alu = 1'b1;
        case (opcode)
            OP_R: begin
                alu_b = b_q;
                case (ir_q[5:0])
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLLV: alu_op = ALU_SLLV;
                    default: is_alu = 1'b0;
                endcase
            end
            OP_ADDI:  alu_op = ALU_ADD;
            OP_ANDI:  begin alu_op = ALU_AND; alu_b = zimm; end
            OP_XORI:  begin alu_op = ALU_XOR; alu_b = zimm; end
            OP_SLTIU: alu_op = ALU_SLTU;
            default:  is_alu = 1'b0;
        endcase
    end

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i (a_q),
        .b_i (alu_b),
        .op_i(alu_op),
        .f_o (f),
        .zf_o(alu_zf),
        .of_o(alu_of)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        zf_d      = zf_q;
        of_d      = of_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                // IR is not loaded yet, so register indices come straight from the ROM output.
                ir_d    = imem_rdata;
                a_d     = regs_q[imem_rdata[25:21]];
                b_d     = regs_q[imem_rdata[20:16]];
                pc_d    = pc_q + PC_W'(1);
                state_d = (imem_rdata[31:26] == OP_HALT) ? S_HALT : S_EX;
            end
            S_EX: begin
                state_d = S_IF;
                if (is_alu) begin
                    alu_out_d = f;
                    zf_d      = alu_zf;
                    of_d      = alu_of;
                    state_d   = S_WB;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    alu_out_d = f;
                    state_d   = S_MEM;
                end else if ((opcode == OP_BEQ && a_q == b_q) || (opcode == OP_BNE && a_q != b_q)) begin
                    pc_d = pc_q + PC_W'(simm);
                end else if (opcode == OP_J) begin
                    pc_d = ir_q[PC_W-1:0];
                end
            end
            S_MEM:   state_d = (opcode == OP_LW) ? S_WB : S_IF;
            S_WB:    state_d = S_IF;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            zf_q      <= zf_d;
            of_q      <= of_d;
            // $0 is never written, so its reset value of zero is what every read returns.
            if (dbg_we && dest != 5'd0) regs_q[dest] <= wdata;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign zf         = zf_q;
    assign of         = of_q;
    assign halt       = (state_q == S_HALT);
    assign dmem_we    = (state_q == S_MEM) && (opcode == OP_SW);
    assign dmem_addr  = alu_out_q[DMEM_AW+1:2];
    assign dmem_wdata = b_q;
    assign dbg_we     = (state_q == S_WB);
    assign dbg_waddr  = dbg_we ? dest : 5'd0;
    assign dbg_wdata  = dbg_we ? wdata : '0;
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: table-driven and directed checks of multi_cycle_cpu at DATA_W 32 and 16.
module tb_multi_cycle_cpu;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        zf;
        logic        of;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst16 = 1'b0;
    logic use16 = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  imem_addr, pc;
    logic [31:0] imem_rdata;
    logic        dmem_we, zf, of, halt, dbg_we;
    logic [5:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata, dbg_wdata;
    logic [4:0]  dbg_waddr;

    logic [7:0]  imem_addr16, pc16;
    logic [31:0] imem_rdata16;
    logic        dmem_we16, zf16, of16, halt16, dbg_we16;
    logic [5:0]  dmem_addr16;
    logic [15:0] dmem_wdata16, dbg_wdata16;
    logic [15:0] dmem_rdata16 = 16'h0;
    logic [4:0]  dbg_waddr16;

    multi_cycle_cpu #(.DATA_W(32), .PC_W(8), .DMEM_AW(6)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .pc(pc), .zf(zf), .of(of), .halt(halt),
        .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata)
    );

    multi_cycle_cpu #(.DATA_W(16), .PC_W(8), .DMEM_AW(6)) dut16 (
        .clk(clk), .rst(rst16), .imem_addr(imem_addr16), .imem_rdata(imem_rdata16),
        .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16), .dmem_rdata(dmem_rdata16),
        .pc(pc16), .zf(zf16), .of(of16), .halt(halt16),
        .dbg_we(dbg_we16), .dbg_waddr(dbg_waddr16), .dbg_wdata(dbg_wdata16)
    );

    logic [31:0] rom [256];
    logic [31:0] rom16 [256];
    logic [31:0] ram [64];
    int          we_cnt = 0;

    always @(posedge clk) begin
        imem_rdata   <= rom[imem_addr];
        imem_rdata16 <= rom16[imem_addr16];
        dmem_rdata   <= ram[dmem_addr];
        if (dmem_we) begin
            ram[dmem_addr] <= dmem_wdata;
            we_cnt         <= we_cnt + 1;
        end
    end

    logic        o_we, o_zf, o_of, o_halt;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [7:0]  o_pc;
    assign o_we    = use16 ? dbg_we16 : dbg_we;
    assign o_waddr = use16 ? dbg_waddr16 : dbg_waddr;
    assign o_wdata = use16 ? {16'h0, dbg_wdata16} : dbg_wdata;
    assign o_zf    = use16 ? zf16 : zf;
    assign o_of    = use16 ? of16 : of;
    assign o_halt  = use16 ? halt16 : halt;
    assign o_pc    = use16 ? pc16 : pc;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {OP_R, 5'(rs), 5'(rt), 5'(rd), 5'b0, fn};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input int wa, input logic [31:0] wd,
                                input logic z, input logic o);
        vec_t v;
        v.ins = ins; v.wa = 5'(wa); v.wd = wd; v.zf = z; v.of = o;
        return v;
    endfunction

    // Called at mid-IF of an ALU-class instruction; returns at mid-IF of the next one.
    task automatic run_alu(input vec_t v, input logic [7:0] npc);
        repeat (2) @(negedge clk);
        chk($sformatf("ex_no_wb[%08h]", v.ins), o_we, 0);
        @(negedge clk);
        chk($sformatf("wb_we[%08h]", v.ins), o_we, 1);
        chk($sformatf("wb_addr[%08h]", v.ins), o_waddr, v.wa);
        chk($sformatf("wb_data[%08h]", v.ins), o_wdata, v.wd);
        chk($sformatf("zf[%08h]", v.ins), o_zf, v.zf);
        chk($sformatf("of[%08h]", v.ins), o_of, v.of);
        @(negedge clk);
        chk($sformatf("next_pc[%08h]", v.ins), o_pc, npc);
    endtask

    vec_t t32 [20];
    vec_t t16 [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt0;
        t32[0]  = mk(ii(OP_ADDI, 0, 1, 16'h7FFF), 1, 32'h00007FFF, 0, 0);
        t32[1]  = mk(ii(OP_ADDI, 0, 2, 16'hFFFF), 2, 32'hFFFFFFFF, 0, 0);
        t32[2]  = mk(rr(1, 2, 3, FN_ADD), 3, 32'h00007FFE, 0, 0);
        t32[3]  = mk(rr(2, 2, 4, FN_SUB), 4, 32'h0, 1, 0);
        t32[4]  = mk(ii(OP_ADDI, 0, 0, 16'h0005), 0, 32'h5, 0, 0);
        t32[5]  = mk(rr(0, 1, 8, FN_ADD), 8, 32'h00007FFF, 0, 0);
        t32[6]  = mk(ii(OP_ADDI, 0, 9, 16'h0001), 9, 32'h1, 0, 0);
        t32[7]  = mk(ii(OP_ADDI, 0, 10, 16'd31), 10, 32'h1F, 0, 0);
        t32[8]  = mk(rr(10, 9, 11, FN_SLLV), 11, 32'h80000000, 0, 0);
        t32[9]  = mk(rr(11, 0, 5, FN_NOR), 5, 32'h7FFFFFFF, 0, 0);
        t32[10] = mk(rr(5, 5, 6, FN_ADD), 6, 32'hFFFFFFFE, 0, 1);
        t32[11] = mk(rr(1, 2, 12, FN_SLTU), 12, 32'h1, 0, 0);
        t32[12] = mk(rr(1, 2, 13, FN_AND), 13, 32'h00007FFF, 0, 0);
        t32[13] = mk(rr(1, 2, 14, FN_XOR), 14, 32'hFFFF8000, 0, 0);
        t32[14] = mk(ii(OP_ANDI, 2, 15, 16'h8001), 15, 32'h00008001, 0, 0);
        t32[15] = mk(ii(OP_XORI, 1, 16, 16'hFFFF), 16, 32'h00008000, 0, 0);
        t32[16] = mk(ii(OP_SLTIU, 1, 17, 16'hFFFF), 17, 32'h1, 0, 0);
        t32[17] = mk(rr(11, 9, 18, FN_SUB), 18, 32'h7FFFFFFF, 0, 1);
        t32[18] = mk(rr(1, 9, 19, FN_OR), 19, 32'h00007FFF, 0, 0);
        t32[19] = mk(rr(2, 1, 21, FN_SLTU), 21, 32'h0, 1, 0);

        t16[0] = mk(ii(OP_ADDI, 0, 1, 16'h7FFF), 1, 32'h7FFF, 0, 0);
        t16[1] = mk(ii(OP_ADDI, 0, 2, 16'hFFFF), 2, 32'hFFFF, 0, 0);
        t16[2] = mk(rr(1, 2, 3, FN_ADD), 3, 32'h7FFE, 0, 0);
        t16[3] = mk(rr(2, 2, 4, FN_SUB), 4, 32'h0, 1, 0);
        t16[4] = mk(ii(OP_ADDI, 0, 0, 16'h0005), 0, 32'h5, 0, 0);
        t16[5] = mk(rr(0, 1, 8, FN_ADD), 8, 32'h7FFF, 0, 0);
        t16[6] = mk(rr(1, 1, 6, FN_ADD), 6, 32'hFFFE, 0, 1);
        t16[7] = mk(rr(1, 2, 10, FN_SLLV), 10, 32'h8000, 0, 0);

        for (int k = 0; k < 256; k++) begin
            rom[k]   = 32'h0;
            rom16[k] = 32'h0;
        end
        for (int k = 0; k < 20; k++) rom[k] = t32[k].ins;
        for (int k = 0; k < 8; k++) rom16[k] = t16[k].ins;
        rom[20] = ii(OP_SW, 0, 1, 16'd8);
        rom[21] = ii(OP_LW, 0, 7, 16'd8);
        rom[22] = rr(7, 0, 20, FN_ADD);
        rom[23] = {OP_HALT, 26'h0};

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_pc", pc, 0);
            chk("rst_halt", halt, 0);
            chk("rst_dmem_we", dmem_we, 0);
            chk("rst_flags", {zf, of}, 0);
            chk("rst_dbg", {dbg_we, dbg_waddr, dbg_wdata}, 0);
        end
        rst = 1'b1;
        chk("first_imem_addr", imem_addr, 0);

        for (int k = 0; k < 20; k++) run_alu(t32[k], 8'(k + 1));

        // sw $1,8($0): one write strobe in MEM
        repeat (2) @(negedge clk);
        chk("sw_ex_we", dmem_we, 0);
        @(negedge clk);
        chk("sw_mem_we", dmem_we, 1);
        chk("sw_addr", dmem_addr, 2);
        chk("sw_wdata", dmem_wdata, 32'h7FFF);
        @(negedge clk);
        chk("sw_we_off", dmem_we, 0);
        chk("sw_pc", pc, 21);
        chk("sw_ram", ram[2], 32'h7FFF);
        chk("sw_pulses", we_cnt, 1);

        // lw $7,8($0): writeback in cycle 5
        repeat (3) @(negedge clk);
        chk("lw_mem_addr", dmem_addr, 2);
        chk("lw_mem_no_wb", dbg_we, 0);
        @(negedge clk);
        chk("lw_wb_addr_stable", dmem_addr, 2);
        chk("lw_wb_we", dbg_we, 1);
        chk("lw_wb_waddr", dbg_waddr, 7);
        chk("lw_wb_data", dbg_wdata, 32'h7FFF);
        @(negedge clk);
        chk("lw_pc", pc, 22);
        run_alu(mk(rr(7, 0, 20, FN_ADD), 20, 32'h7FFF, 0, 0), 8'd23);

        // halt: reaches HALT two cycles after IF, pc frozen
        chk("halt_if", halt, 0);
        @(negedge clk);
        chk("halt_id", halt, 0);
        @(negedge clk);
        chk("halt_on", halt, 1);
        chk("halt_pc", pc, 24);
        repeat (4) @(negedge clk);
        chk("halt_stays", halt, 1);
        chk("halt_pc_frozen", pc, 24);
        chk("halt_no_wb", dbg_we, 0);

        // Control flow
        rst = 1'b0;
        for (int k = 0; k < 256; k++) rom[k] = 32'h0;
        rom[0]   = {OP_J, 26'd10};
        rom[10]  = ii(OP_BEQ, 0, 0, 16'hFFFF);
        rom[11]  = {OP_J, 26'hFF};
        rom[255] = {OP_J, 26'hFF};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("j_10", pc, 10);
        repeat (3) @(negedge clk);
        chk("beq_back", pc, 10);
        rom[10] = ii(OP_BNE, 0, 0, 16'd3);
        repeat (3) @(negedge clk);
        chk("bne_not_taken", pc, 11);
        repeat (3) @(negedge clk);
        chk("j_ff", pc, 8'hFF);
        repeat (3) @(negedge clk);
        chk("j_ff_self", pc, 8'hFF);
        rom[255] = {OP_HALT, 26'h0};
        repeat (2) @(negedge clk);
        chk("halt_ff", halt, 1);
        chk("halt_pc_wrap", pc, 0);
        repeat (3) @(negedge clk);
        chk("halt_ff_frozen", pc, 0);

        // Reset during MEM of sw aborts the write
        rst = 1'b0;
        for (int k = 0; k < 256; k++) rom[k] = 32'h0;
        rom[0] = ii(OP_SW, 0, 1, 16'd8);
        cnt0 = we_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_we", dmem_we, 0);
        chk("abort_pc", pc, 0);
        repeat (2) @(negedge clk);
        chk("abort_ram", ram[2], 32'h7FFF);
        chk("abort_pulses", we_cnt, cnt0);

        // DATA_W = 16 ALU sequence
        use16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b1;
        chk("w16_first_pc", o_pc, 0);
        for (int k = 0; k < 8; k++) run_alu(t16[k], 8'(k + 1));
        chk("w16_halt", o_halt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
